// File: rtl/snitch_icache_refill_writer_if.sv
// Purpose: bundles the miss, memory request/response, lookup write and done
//          signals of the icache refill writer into one interface.
// Signals (direction as seen from the refill writer):
//   miss_*      in/out  miss handshake (addr, id, valid in; ready out)
//   mem_req_*   out/in  line-aligned memory request (addr, valid out; ready in)
//   mem_rsp_*   in/out  memory response beats (data, error, last, valid in; ready out)
//   write_*     out/in  lookup RAM write port (addr, set, data, tag, error, valid out; ready in)
//   done_*      out     one-cycle completion pulse with the miss ID
// Modports: master = refill writer, slave = environment (fetch side, memory, RAMs).
interface snitch_icache_refill_writer_if #(
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned FILL_DW    = 64,
  parameter int unsigned SET_COUNT  = 2,
  parameter int unsigned LINE_COUNT = 32,
  parameter int unsigned ID_W       = 4
) ();
  localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
  localparam int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;
  localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN;

  logic [FETCH_AW-1:0]    miss_addr_i;
  logic [ID_W-1:0]        miss_id_i;
  logic                   miss_valid_i;
  logic                   miss_ready_o;

  logic [FETCH_AW-1:0]    mem_req_addr_o;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;

  logic [FILL_DW-1:0]     mem_rsp_data_i;
  logic                   mem_rsp_error_i;
  logic                   mem_rsp_last_i;
  logic                   mem_rsp_valid_i;
  logic                   mem_rsp_ready_o;

  logic [COUNT_ALIGN-1:0] write_addr_o;
  logic [SET_ALIGN-1:0]   write_set_o;
  logic [LINE_WIDTH-1:0]  write_data_o;
  logic [TAG_WIDTH-1:0]   write_tag_o;
  logic                   write_error_o;
  logic                   write_valid_o;
  logic                   write_ready_i;

  logic [ID_W-1:0]        done_id_o;
  logic                   done_valid_o;

  modport master (
    input  miss_addr_i, miss_id_i, miss_valid_i,
    output miss_ready_o,
    output mem_req_addr_o, mem_req_valid_o,
    input  mem_req_ready_i,
    input  mem_rsp_data_i, mem_rsp_error_i, mem_rsp_last_i, mem_rsp_valid_i,
    output mem_rsp_ready_o,
    output write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
    input  write_ready_i,
    output done_id_o, done_valid_o
  );

  modport slave (
    output miss_addr_i, miss_id_i, miss_valid_i,
    input  miss_ready_o,
    input  mem_req_addr_o, mem_req_valid_o,
    output mem_req_ready_i,
    output mem_rsp_data_i, mem_rsp_error_i, mem_rsp_last_i, mem_rsp_valid_i,
    input  mem_rsp_ready_o,
    input  write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
    output write_ready_i,
    input  done_id_o, done_valid_o
  );
endinterface

// File: rtl/snitch_icache_refill_writer.sv
// Purpose: write side of the icache lookup RAMs. Accepts one line miss at a
//          time, requests the aligned line from memory, assembles FILL_DW beats
//          into a line, picks a victim set round-robin, writes the lookup RAMs
//          and pulses done with the miss ID so waiting fetches can retry.
// Ports:
//   clk_i    clock
//   rst_i    synchronous reset, active high
//   flush_i  drops the in-flight refill and resets the victim pointer
//   bus      miss / memory / write / done signals (interface, master side)
module snitch_icache_refill_writer #(
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned FILL_DW    = 64,
  parameter int unsigned SET_COUNT  = 2,
  parameter int unsigned LINE_COUNT = 32,
  parameter int unsigned ID_W       = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  snitch_icache_refill_writer_if.master bus
);
  localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8);
  localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT);
  localparam int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;
  localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN;
  localparam int unsigned BEATS       = LINE_WIDTH / FILL_DW;
  localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Clears the byte-offset bits so the memory request is line aligned.
  localparam logic [FETCH_AW-1:0] ALIGN_MASK =
    ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RECV  = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [FETCH_AW-1:0]   addr_q, addr_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  error_q, error_d;
  logic                  drop_q, drop_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [SET_ALIGN-1:0]  victim_q, victim_d;
  logic                  done_valid_s;

  // Next-state logic and the only input-dependent output (done pulse).
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    id_d         = id_q;
    line_d       = line_q;
    error_d      = error_q;
    drop_d       = drop_q;
    beat_d       = beat_q;
    victim_d     = victim_q;
    done_valid_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.miss_valid_i) begin
          addr_d  = bus.miss_addr_i;
          id_d    = bus.miss_id_i;
          line_d  = '0;
          error_d = 1'b0;
          drop_d  = 1'b0;
          beat_d  = '0;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (flush_i) drop_d = 1'b1;
        else         drop_d = drop_q;
        if (bus.mem_req_ready_i) state_d = RECV;
        else                     state_d = REQ;
      end
      RECV: begin
        if (flush_i) drop_d = 1'b1;
        else         drop_d = drop_q;
        if (bus.mem_rsp_valid_i) begin
          for (int k = 0; k < int'(BEATS); k++) begin
            if (beat_q == BEAT_W'(k)) line_d[k*FILL_DW +: FILL_DW] = bus.mem_rsp_data_i;
          end
          error_d = error_q | bus.mem_rsp_error_i;
          if (bus.mem_rsp_last_i) begin
            // A short response leaves the tail of the line zero and flags it.
            if (beat_q != BEAT_W'(BEATS - 1)) error_d = 1'b1;
            state_d = WRITE;
          end else if (beat_q == BEAT_W'(BEATS - 1)) begin
            // Line is full but memory keeps sending: swallow the excess.
            error_d = 1'b1;
            state_d = DRAIN;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = RECV;
        end
      end
      DRAIN: begin
        if (flush_i) drop_d = 1'b1;
        else         drop_d = drop_q;
        if (bus.mem_rsp_valid_i && bus.mem_rsp_last_i) state_d = WRITE;
        else                                           state_d = DRAIN;
      end
      WRITE: begin
        if (drop_q) begin
          // Dropped line: skip the RAM write but still release the waiters.
          done_valid_s = 1'b1;
          state_d      = IDLE;
        end else if (bus.write_ready_i) begin
          done_valid_s = 1'b1;
          if (victim_q == SET_ALIGN'(SET_COUNT - 1)) victim_d = '0;
          else                                       victim_d = victim_q + SET_ALIGN'(1);
          state_d = IDLE;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) victim_d = '0;
    else         victim_d = victim_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      line_q   <= '0;
      error_q  <= 1'b0;
      drop_q   <= 1'b0;
      beat_q   <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      id_q     <= id_d;
      line_q   <= line_d;
      error_q  <= error_d;
      drop_q   <= drop_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
    end
  end

  // Handshake outputs come from state only; data outputs straight from registers.
  assign bus.miss_ready_o    = (state_q == IDLE);
  assign bus.mem_req_valid_o = (state_q == REQ);
  assign bus.mem_req_addr_o  = addr_q & ALIGN_MASK;
  assign bus.mem_rsp_ready_o = (state_q == RECV) || (state_q == DRAIN);
  assign bus.write_valid_o   = (state_q == WRITE) && !drop_q;
  assign bus.write_addr_o    = addr_q[LINE_ALIGN +: COUNT_ALIGN];
  assign bus.write_tag_o     = addr_q[FETCH_AW-1 -: TAG_WIDTH];
  assign bus.write_set_o     = victim_q;
  assign bus.write_data_o    = line_q;
  assign bus.write_error_o   = error_q;
  assign bus.done_id_o       = id_q;
  assign bus.done_valid_o    = done_valid_s;
endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
module tb_snitch_icache_refill_writer;
  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snitch_icache_refill_writer_if ifc ();
  snitch_icache_refill_writer_if #(.SET_COUNT(3)) if3 ();

  // Second DUT (three sets) sees exactly the same stimulus.
  assign if3.miss_addr_i     = ifc.miss_addr_i;
  assign if3.miss_id_i       = ifc.miss_id_i;
  assign if3.miss_valid_i    = ifc.miss_valid_i;
  assign if3.mem_req_ready_i = ifc.mem_req_ready_i;
  assign if3.mem_rsp_data_i  = ifc.mem_rsp_data_i;
  assign if3.mem_rsp_error_i = ifc.mem_rsp_error_i;
  assign if3.mem_rsp_last_i  = ifc.mem_rsp_last_i;
  assign if3.mem_rsp_valid_i = ifc.mem_rsp_valid_i;
  assign if3.write_ready_i   = ifc.write_ready_i;

  snitch_icache_refill_writer dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(ifc.master)
  );
  snitch_icache_refill_writer #(.SET_COUNT(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if3.master)
  );

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL timeout %s: waited 20 cycles, required handshake", what);
  endtask

  task automatic clear_inputs();
    ifc.miss_addr_i     = 32'h0;
    ifc.miss_id_i       = 4'h0;
    ifc.miss_valid_i    = 1'b0;
    ifc.mem_req_ready_i = 1'b0;
    ifc.mem_rsp_data_i  = 64'h0;
    ifc.mem_rsp_error_i = 1'b0;
    ifc.mem_rsp_last_i  = 1'b0;
    ifc.mem_rsp_valid_i = 1'b0;
    ifc.write_ready_i   = 1'b0;
    flush               = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accept a miss and complete its memory request; returns the request address.
  task automatic start_miss(input logic [31:0] addr, input logic [3:0] id,
                            output logic [31:0] req_addr, output int c0);
    int n;
    ifc.miss_addr_i  = addr;
    ifc.miss_id_i    = id;
    ifc.miss_valid_i = 1'b1;
    n = 0;
    while (ifc.miss_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("miss_ready");
    @(negedge clk);
    ifc.miss_valid_i = 1'b0;
    c0 = cyc;
    n = 0;
    while (ifc.mem_req_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("mem_req_valid");
    req_addr = ifc.mem_req_addr_o;
    ifc.mem_req_ready_i = 1'b1;
    @(negedge clk);
    ifc.mem_req_ready_i = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic err, input logic last);
    int n;
    ifc.mem_rsp_data_i  = d;
    ifc.mem_rsp_error_i = err;
    ifc.mem_rsp_last_i  = last;
    ifc.mem_rsp_valid_i = 1'b1;
    n = 0;
    while (ifc.mem_rsp_ready_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("mem_rsp_ready");
    @(negedge clk);
    ifc.mem_rsp_valid_i = 1'b0;
    ifc.mem_rsp_error_i = 1'b0;
    ifc.mem_rsp_last_i  = 1'b0;
  endtask

  // Full refill; captures the write port and checks hold/done behaviour into flags.
  task automatic refill(input logic [31:0] addr, input logic [3:0] id, input int nb,
                        input logic [63:0] d0, d1, d2, input logic [2:0] errs, lasts,
                        input int wr_wait,
                        output logic [31:0] req_addr, output int lat,
                        output logic [127:0] wdata, output logic [4:0] waddr,
                        output logic [22:0] wtag, output logic wset, output logic [1:0] wset3,
                        output logic werr, output logic hold_ok, output logic done_ok);
    int n;
    int c0;
    hold_ok = 1'b1;
    done_ok = 1'b1;
    start_miss(addr, id, req_addr, c0);
    for (int i = 0; i < nb; i++)
      send_beat((i == 0) ? d0 : (i == 1) ? d1 : d2, errs[i], lasts[i]);
    n = 0;
    while (ifc.write_valid_o !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("write_valid");
    lat   = cyc - c0;
    wdata = ifc.write_data_o;
    waddr = ifc.write_addr_o;
    wtag  = ifc.write_tag_o;
    wset  = ifc.write_set_o;
    wset3 = if3.write_set_o;
    werr  = ifc.write_error_o;
    for (int k = 0; k < wr_wait; k++) begin
      @(negedge clk);
      if (ifc.write_valid_o !== 1'b1 || ifc.write_data_o !== wdata ||
          ifc.write_addr_o !== waddr || ifc.write_tag_o !== wtag ||
          ifc.write_set_o !== wset || ifc.write_error_o !== werr ||
          ifc.miss_ready_o !== 1'b0 || ifc.done_valid_o !== 1'b0)
        hold_ok = 1'b0;
    end
    ifc.write_ready_i = 1'b1;
    #1;
    if (ifc.done_valid_o !== 1'b1 || ifc.done_id_o !== id) done_ok = 1'b0;
    @(negedge clk);
    ifc.write_ready_i = 1'b0;
    if (ifc.done_valid_o !== 1'b0 || ifc.miss_ready_o !== 1'b1) done_ok = 1'b0;
  endtask

  logic [31:0]  r_req;
  int           r_lat;
  logic [127:0] r_data;
  logic [4:0]   r_addr;
  logic [22:0]  r_tag;
  logic         r_set;
  logic [1:0]   r_set3;
  logic         r_err;
  logic         r_hold;
  logic         r_done;

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ifc.mem_req_valid_o, ifc.mem_rsp_ready_o, ifc.write_valid_o, ifc.done_valid_o,
         ifc.write_error_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 00000", {ifc.mem_req_valid_o,
               ifc.mem_rsp_ready_o, ifc.write_valid_o, ifc.done_valid_o, ifc.write_error_o});
    end
    checks++;
    if (ifc.write_data_o !== 128'h0 || ifc.mem_req_addr_o !== 32'h0 || ifc.write_set_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: data %h addr %h set %b, required 0", ifc.write_data_o,
               ifc.mem_req_addr_o, ifc.write_set_o);
    end
    checks++;
    if (ifc.miss_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_miss_ready: got %b, required 1", ifc.miss_ready_o);
    end
  endtask

  task automatic test_basic();
    refill(32'h0000_1234, 4'd3, 2, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'h0,
           3'b000, 3'b010, 0, r_req, r_lat, r_data, r_addr, r_tag, r_set, r_set3, r_err, r_hold, r_done);
    checks++;
    if (r_req !== 32'h0000_1230) begin errors++; $display("FAIL basic_req_addr: got %h, required 00001230", r_req); end
    checks++;
    if (r_lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d, required 3", r_lat); end
    checks++;
    if (r_data !== {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}) begin
      errors++; $display("FAIL basic_data: got %h, required BBBB..AAAA..", r_data);
    end
    checks++;
    if (r_addr !== 5'd3 || r_tag !== 23'h9) begin
      errors++; $display("FAIL basic_addr_tag: got addr %0d tag %h, required 3 and 9", r_addr, r_tag);
    end
    checks++;
    if (r_set !== 1'b0 || r_err !== 1'b0) begin
      errors++; $display("FAIL basic_set_err: got set %b err %b, required 0 0", r_set, r_err);
    end
    checks++;
    if (r_done !== 1'b1) begin errors++; $display("FAIL basic_done: got bad pulse, required one pulse with id 3"); end
  endtask

  task automatic test_errors();
    refill(32'h0000_2000, 4'd1, 2, 64'h1111_0000_1111_0000, 64'h2222_0000_2222_0000, 64'h0,
           3'b001, 3'b010, 0, r_req, r_lat, r_data, r_addr, r_tag, r_set, r_set3, r_err, r_hold, r_done);
    checks++;
    if (r_err !== 1'b1 || r_data !== {64'h2222_0000_2222_0000, 64'h1111_0000_1111_0000}) begin
      errors++; $display("FAIL beat_error: got err %b data %h, required err 1", r_err, r_data);
    end
    refill(32'h0000_3040, 4'd2, 1, 64'hCAFE_F00D_1234_5678, 64'h0, 64'h0,
           3'b000, 3'b001, 0, r_req, r_lat, r_data, r_addr, r_tag, r_set, r_set3, r_err, r_hold, r_done);
    checks++;
    if (r_err !== 1'b1 || r_data !== {64'h0, 64'hCAFE_F00D_1234_5678}) begin
      errors++; $display("FAIL early_last: got err %b data %h, required err 1 upper 0", r_err, r_data);
    end
    checks++;
    if (r_addr !== 5'd4 || r_tag !== 23'h18) begin
      errors++; $display("FAIL early_last_addr: got addr %0d tag %h, required 4 and 18", r_addr, r_tag);
    end
    refill(32'h0000_0010, 4'd4, 3, 64'hD0D0_D0D0_D0D0_D0D0, 64'hD1D1_D1D1_D1D1_D1D1,
           64'hD2D2_D2D2_D2D2_D2D2, 3'b000, 3'b100, 0,
           r_req, r_lat, r_data, r_addr, r_tag, r_set, r_set3, r_err, r_hold, r_done);
    checks++;
    if (r_err !== 1'b1 || r_data !== {64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0}) begin
      errors++; $display("FAIL drain: got err %b data %h, required err 1 data D1..D0..", r_err, r_data);
    end
  endtask

  task automatic test_stall();
    refill(32'h0000_4560, 4'd6, 2, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0,
           3'b000, 3'b010, 5, r_req, r_lat, r_data, r_addr, r_tag, r_set, r_set3, r_err, r_hold, r_done);
    checks++;
    if (r_hold !== 1'b1) begin errors++; $display("FAIL stall_hold: got unstable outputs, required stable"); end
    checks++;
    if (r_done !== 1'b1) begin errors++; $display("FAIL stall_done: got bad pulse, required one pulse id 6"); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s2;
    logic [7:0] s3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      refill(32'h0001_0000 + 32'(i * 16), 4'(i), 2, 64'(i), 64'(i + 100), 64'h0,
             3'b000, 3'b010, 0, r_req, r_lat, r_data, r_addr, r_tag, r_set, r_set3, r_err, r_hold, r_done);
      s2[i]       = r_set;
      s3[i*2 +: 2] = r_set3;
    end
    checks++;
    if (s2 !== 4'b1010) begin errors++; $display("FAIL rr_two_sets: got %b (msb=4th), required 1010", s2); end
    checks++;
    if (s3 !== 8'b00_10_01_00) begin errors++; $display("FAIL rr_three_sets: got %b, required 00100100", s3); end
  endtask

  task automatic test_flush();
    int c0;
    int done_cnt;
    logic saw_wv;
    refill(32'h0000_5000, 4'd7, 2, 64'h5, 64'h6, 64'h0, 3'b000, 3'b010, 0,
           r_req, r_lat, r_data, r_addr, r_tag, r_set, r_set3, r_err, r_hold, r_done);
    start_miss(32'h0000_6000, 4'd5, r_req, c0);
    flush = 1'b1;
    send_beat(64'h77, 1'b0, 1'b0);
    flush = 1'b0;
    send_beat(64'h88, 1'b0, 1'b1);
    done_cnt = 0;
    saw_wv   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (ifc.write_valid_o === 1'b1) saw_wv = 1'b1;
      if (ifc.done_valid_o === 1'b1 && ifc.done_id_o === 4'd5) done_cnt++;
      @(negedge clk);
    end
    checks++;
    if (saw_wv !== 1'b0) begin errors++; $display("FAIL flush_no_write: got write_valid 1, required 0"); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL flush_done: got %0d pulses, required 1", done_cnt); end
    refill(32'h0000_7000, 4'd8, 2, 64'h9, 64'hA, 64'h0, 3'b000, 3'b010, 0,
           r_req, r_lat, r_data, r_addr, r_tag, r_set, r_set3, r_err, r_hold, r_done);
    checks++;
    if (r_set !== 1'b0 || r_set3 !== 2'd0 || r_err !== 1'b0) begin
      errors++; $display("FAIL flush_victim: got set %b set3 %0d err %b, required 0 0 0", r_set, r_set3, r_err);
    end
  endtask

  task automatic test_reset_in_recv();
    int c0;
    start_miss(32'h0000_8ABC, 4'd9, r_req, c0);
    send_beat(64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ifc.mem_req_valid_o, ifc.mem_rsp_ready_o, ifc.write_valid_o, ifc.done_valid_o,
         ifc.write_error_o} !== 5'b0 || ifc.write_data_o !== 128'h0 || ifc.mem_req_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_recv: got ctrl %b data %h addr %h, required all 0",
               {ifc.mem_req_valid_o, ifc.mem_rsp_ready_o, ifc.write_valid_o, ifc.done_valid_o,
                ifc.write_error_o}, ifc.write_data_o, ifc.mem_req_addr_o);
    end
    checks++;
    if (ifc.miss_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_in_recv_idle: got miss_ready %b, required 1", ifc.miss_ready_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_errors();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_in_recv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
